hbmc_rx_word_aligner: RTL and testbench

//  - Parametrised RWDS-qualified read-data recovery stage; sits directly after the per-lane ISERDES capture logic.
//  - Receives oversampled DQ lanes and an RWDS lane, one SERDES word per cycle, and detects RWDS transitions.
//  - Assembles 2*NUM_LANES-bit HyperBus words and buffers them in a FIFO with a valid/ready output.
//  - Generalises the fixed two-cycle post-reset invalidation to a parameter.

---
 rtl/hbmc_rx_word_aligner_if.sv | 15 +
 rtl/hbmc_rx_word_aligner.sv | 194 +++++++++++++++++++
 tb/tb_hbmc_rx_word_aligner.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hbmc_rx_word_aligner_if.sv
// hbmc_rx_word_aligner_if: output word stream of the RX word aligner.
//   o_data   {rising-edge byte, falling-edge byte} at the FIFO head
//   o_valid  FIFO head valid
//   o_ready  consumer accepts the head when o_valid && o_ready
// master = aligner (drives data/valid), slave = consumer (drives ready).
interface hbmc_rx_word_aligner_if #(
    parameter int unsigned NUM_LANES = 8
);
    logic [2*NUM_LANES-1:0] o_data;
    logic                   o_valid;
    logic                   o_ready;

    modport master (output o_data, output o_valid, input o_ready);
    modport slave  (input o_data, input o_valid, output o_ready);
endinterface

// File: rtl/hbmc_rx_word_aligner.sv
// hbmc_rx_word_aligner: RWDS-qualified read-data recovery after the ISERDES.
// Registers one SERDES word per cycle, scans RWDS samples oldest to newest,
// pairs a rising-edge DQ byte with the following falling-edge DQ byte and
// pushes the 2*NUM_LANES-bit word into a first-word-fall-through FIFO.
// Ports:
//   clk, arst      divided SERDES clock; async active-high reset
//   rx_en          capture window; low clears edge state one cycle later
//   dq_q           lane l at [l*SERDES_WIDTH +: SERDES_WIDTH], bit SW-1 oldest
//   rwds_q         RWDS samples, same ordering as dq_q
//   out_if         o_data/o_valid/o_ready output stream (master side)
//   overflow       sticky, word dropped on a full FIFO
//   edge_err       sticky, more than two RWDS edges in one input word
//   word_count     pushed-word counter, present only with HBMC_RX_WORD_COUNT_EN
// Optional feature macro: HBMC_RX_WORD_COUNT_EN.
module hbmc_rx_word_aligner #(
    parameter int unsigned NUM_LANES      = 8,
    parameter int unsigned SERDES_WIDTH   = 6,
    parameter int unsigned INVALID_CYCLES = 2,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                               clk,
    input  logic                               arst,
    input  logic                               rx_en,
    input  logic [NUM_LANES*SERDES_WIDTH-1:0]  dq_q,
    input  logic [SERDES_WIDTH-1:0]            rwds_q,
    hbmc_rx_word_aligner_if.master             out_if,
    output logic                               overflow,
    output logic                               edge_err,
    output logic [15:0]                        word_count
);
    localparam int unsigned DQ_W   = NUM_LANES * SERDES_WIDTH;
    localparam int unsigned WORD_W = 2 * NUM_LANES;
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned KW     = $clog2(SERDES_WIDTH);
    localparam int unsigned RW     = $clog2(SERDES_WIDTH + 1);
    localparam int unsigned INV_W  = (INVALID_CYCLES > 0) ? INVALID_CYCLES : 1;

    // Post-reset invalidation window
    logic inv_active;
    if (INVALID_CYCLES > 0) begin : g_inv
        logic [INV_W-1:0] inv_sr;
        always_ff @(posedge clk or posedge arst) begin
            if (arst) inv_sr <= '1;
            else      inv_sr <= inv_sr >> 1;
        end
        assign inv_active = |inv_sr;
    end else begin : g_no_inv
        assign inv_active = 1'b0;
    end

    // Stage 1: input capture
    logic [DQ_W-1:0]         dq_s1;
    logic [SERDES_WIDTH-1:0] rwds_s1;
    logic                    en_s1;
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            dq_s1   <= '0;
            rwds_s1 <= '0;
            en_s1   <= 1'b0;
        end else begin
            en_s1 <= rx_en;
            if (inv_active) begin
                dq_s1   <= '0;
                rwds_s1 <= '0;
            end else begin
                dq_s1   <= dq_q;
                rwds_s1 <= rwds_q;
            end
        end
    end

    // Per-sample DQ byte: dq_by_k[k][l] = lane l, sample k
    logic [NUM_LANES-1:0] dq_by_k [SERDES_WIDTH];
    for (genvar k = 0; k < SERDES_WIDTH; k++) begin : g_k
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_l
            assign dq_by_k[k][l] = dq_s1[l*SERDES_WIDTH + k];
        end
    end

    // Stage 2: edge scan, oldest sample first; only the first two edges act
    logic                  prev_rwds, pending, pend_nxt;
    logic [NUM_LANES-1:0]  hi_byte, hi_nxt, samp;
    logic [SERDES_WIDTH:0] rwds_ext;
    logic [1:0]            edge_cnt;
    logic                  push_c, err_c;
    logic [WORD_W-1:0]     push_data;
    always_comb begin
        hi_nxt    = hi_byte;
        pend_nxt  = pending;
        push_c    = 1'b0;
        push_data = '0;
        err_c     = 1'b0;
        edge_cnt  = '0;
        samp      = '0;
        rwds_ext  = {prev_rwds, rwds_s1};
        if (en_s1) begin
            for (int k = int'(SERDES_WIDTH) - 1; k >= 0; k--) begin
                samp = dq_by_k[KW'(k)];
                if (rwds_ext[RW'(k)] != rwds_ext[RW'(k + 1)]) begin
                    if (edge_cnt == 2'd2) begin
                        err_c = 1'b1;
                    end else begin
                        edge_cnt = edge_cnt + 2'd1;
                        if (rwds_ext[RW'(k)]) begin
                            hi_nxt   = samp;
                            pend_nxt = 1'b1;
                        end else if (pend_nxt) begin
                            push_c    = 1'b1;
                            push_data = {hi_nxt, samp};
                            pend_nxt  = 1'b0;
                        end
                    end
                end
            end
        end else begin
            pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            prev_rwds <= 1'b0;
            pending   <= 1'b0;
            hi_byte   <= '0;
        end else begin
            prev_rwds <= en_s1 ? rwds_s1[0] : 1'b0;
            pending   <= pend_nxt;
            hi_byte   <= hi_nxt;
        end
    end

    // FIFO with registered head; o_valid mirrors count != 0
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic              o_valid_q, pop, full, push_ok, en_rise;
    logic [WORD_W-1:0] o_data_q;

    assign pop       = o_valid_q & out_if.o_ready;
    assign full      = (count == CW'(FIFO_DEPTH));
    assign push_ok   = push_c & (~full | pop);
    assign count_nxt = count + CW'(push_ok) - CW'(pop);
    assign rd_nxt    = rd_ptr + AW'(pop);
    assign en_rise   = rx_en & ~en_s1;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push_ok);
            rd_ptr    <= rd_nxt;
            count     <= count_nxt;
            o_valid_q <= (count_nxt != '0);
            // A word pushed into an otherwise-empty FIFO bypasses the array
            if (count_nxt != '0)
                o_data_q <= ((count - CW'(pop)) == '0) ? push_data : mem[rd_nxt];
        end
    end

    assign out_if.o_data  = o_data_q;
    assign out_if.o_valid = o_valid_q;

    // Sticky flags, cleared when the capture window reopens
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            overflow <= 1'b0;
            edge_err <= 1'b0;
        end else begin
            if (en_rise)                   overflow <= 1'b0;
            else if (push_c & full & ~pop) overflow <= 1'b1;
            if (en_rise)                   edge_err <= 1'b0;
            else if (err_c)                edge_err <= 1'b1;
        end
    end

`ifdef HBMC_RX_WORD_COUNT_EN
    // Saturating count of accepted pushes
    always_ff @(posedge clk or posedge arst) begin
        if (arst)                                   word_count <= 16'h0000;
        else if (push_ok && word_count != 16'hFFFF) word_count <= word_count + 16'd1;
    end
`else
    assign word_count = 16'h0000;
`endif
endmodule

// File: tb/tb_hbmc_rx_word_aligner.sv
// tb_hbmc_rx_word_aligner: directed + randomized bench with a queue-based
// reference model of the word aligner, compared every cycle.
module tb_hbmc_rx_word_aligner;
    localparam int unsigned NL = 8, SW = 6, IC = 2, DEPTH = 8;
    localparam int unsigned DW = NL * SW, WW = 2 * NL;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic          rx_en = 1'b0;
    logic [DW-1:0] dq_q = '0;
    logic [SW-1:0] rwds_q = '0;
    logic          overflow, edge_err;
    logic [15:0]   word_count;

    hbmc_rx_word_aligner_if #(.NUM_LANES(NL)) out_if ();

    hbmc_rx_word_aligner #(
        .NUM_LANES(NL), .SERDES_WIDTH(SW), .INVALID_CYCLES(IC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .arst(arst), .rx_en(rx_en), .dq_q(dq_q), .rwds_q(rwds_q),
        .out_if(out_if), .overflow(overflow), .edge_err(edge_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model state
    logic [WW-1:0] mq[$];
    logic          m_prev, m_pend, m_ovf, m_err;
    logic [NL-1:0] m_hi;
    int            m_inv;
    int unsigned   m_cnt;
    logic          d_en;
    logic [DW-1:0] d_dq;
    logic [SW-1:0] d_rwds;

    function automatic logic [DW-1:0] put(input logic [DW-1:0] base, input logic [NL-1:0] b, input int k);
        logic [DW-1:0] r;
        r = base;
        for (int l = 0; l < int'(NL); l++) r[l*SW + k] = b[l];
        return r;
    endfunction

    function automatic logic [NL-1:0] lane_bits(input logic [DW-1:0] dq, input int k);
        logic [NL-1:0] b;
        for (int l = 0; l < int'(NL); l++) b[l] = dq[l*SW + k];
        return b;
    endfunction

    function automatic logic [DW-1:0] rnd_dq();
        return DW'({$urandom(), $urandom()});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_prev = 1'b0; m_pend = 1'b0; m_hi = '0; m_ovf = 1'b0; m_err = 1'b0;
        m_inv = 0; m_cnt = 0; d_en = 1'b0; d_dq = '0; d_rwds = '0;
    endtask

    // One clock edge: the word captured last edge is scanned, this edge's inputs are captured
    task automatic model_step(input logic en, input logic [DW-1:0] dq, input logic [SW-1:0] rw, input logic rdy);
        bit            pop, have;
        logic [WW-1:0] w;
        int            nedge;
        logic          last;
        pop  = (mq.size() != 0) && rdy;
        have = 0;
        w    = '0;
        if (d_en) begin
            nedge = 0;
            last  = m_prev;
            for (int k = SW - 1; k >= 0; k--) begin
                if (d_rwds[k] != last) begin
                    nedge++;
                    if (nedge <= 2) begin
                        if (d_rwds[k]) begin
                            m_hi = lane_bits(d_dq, k); m_pend = 1'b1;
                        end else if (m_pend) begin
                            w = {m_hi, lane_bits(d_dq, k)}; have = 1; m_pend = 1'b0;
                        end
                    end
                end
                last = d_rwds[k];
            end
            if (nedge > 2) m_err = 1'b1;
            m_prev = d_rwds[0];
        end else begin
            m_pend = 1'b0;
            m_prev = 1'b0;
        end
        if (pop) void'(mq.pop_front());
        if (have) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(w);
`ifdef HBMC_RX_WORD_COUNT_EN
                if (m_cnt < 32'hFFFF) m_cnt++;
`endif
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (en && !d_en) begin m_ovf = 1'b0; m_err = 1'b0; end
        d_en = en;
        if (m_inv < int'(IC)) begin
            d_dq = '0; d_rwds = '0; m_inv++;
        end else begin
            d_dq = dq; d_rwds = rw;
        end
    endtask

    task automatic compare_all();
        chk("o_valid", 32'(out_if.o_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("o_data", 32'(out_if.o_data), 32'(mq[0]));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("edge_err", 32'(edge_err), 32'(m_err));
        chk("word_count", 32'(word_count), m_cnt);
    endtask

    task automatic tick(input logic en, input logic [DW-1:0] dq, input logic [SW-1:0] rw, input logic rdy);
        rx_en = en; dq_q = dq; rwds_q = rw; out_if.o_ready = rdy;
        @(posedge clk);
        model_step(en, dq, rw, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        #2;
        arst = 1'b1; rx_en = 1'b0; dq_q = '0; rwds_q = '0; out_if.o_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        arst = 1'b0;
    endtask

    initial begin
        logic [WW-1:0] exp4 [DEPTH+1];
        logic [NL-1:0] hb, lb;
        int            n;
        logic [SW-1:0] lvl;

        out_if.o_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();
        chk("rst_o_valid", 32'(out_if.o_valid), 32'd0);
        chk("rst_o_data", 32'(out_if.o_data), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_edge_err", 32'(edge_err), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);

        // Invalidation window swallows RWDS edges
        tick(1'b1, rnd_dq(), 6'b000111, 1'b1);
        tick(1'b1, rnd_dq(), 6'b000111, 1'b1);
        tick(1'b1, '0, 6'b000000, 1'b1);
        tick(1'b1, '0, 6'b000000, 1'b1);
        chk("inv_no_push", 32'(out_if.o_valid), 32'd0);
        chk("inv_overflow", 32'(overflow), 32'd0);

        // Single word inside one input word
        tick(1'b1, put(put('0, 8'hA5, 5), 8'h3C, 2), 6'b111000, 1'b1);
        chk("t2_lat1_valid", 32'(out_if.o_valid), 32'd0);
        tick(1'b1, '0, 6'b000000, 1'b1);
        chk("t2_valid", 32'(out_if.o_valid), 32'd1);
        chk("t2_data", 32'(out_if.o_data), 32'h0000A53C);
        tick(1'b1, '0, 6'b000000, 1'b1);

        // Word spanning a cycle boundary
        tick(1'b1, put('0, 8'h12, 0), 6'b000001, 1'b1);
        tick(1'b1, put('0, 8'h34, 3), 6'b110000, 1'b1);
        chk("t3_not_yet", 32'(out_if.o_valid), 32'd0);
        tick(1'b1, '0, 6'b000000, 1'b1);
        chk("t3_valid", 32'(out_if.o_valid), 32'd1);
        chk("t3_data", 32'(out_if.o_data), 32'h00001234);
        tick(1'b1, '0, 6'b000000, 1'b1);

        // Backpressure: DEPTH+1 words into a stalled FIFO
        for (int i = 0; i <= int'(DEPTH); i++) begin
            hb = NL'($urandom()); lb = NL'($urandom());
            exp4[i] = {hb, lb};
            tick(1'b1, put(put(rnd_dq(), hb, 5), lb, 2), 6'b111000, 1'b0);
        end
        tick(1'b1, '0, 6'b000000, 1'b0);
        chk("t4_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < int'(DEPTH); i++) begin
            chk("t4_order", 32'(out_if.o_data), 32'(exp4[i]));
            tick(1'b0, '0, 6'b000000, 1'b1);
        end
        chk("t4_drained", 32'(out_if.o_valid), 32'd0);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);
        tick(1'b1, '0, 6'b000000, 1'b1);
        chk("t4_ovf_clear", 32'(overflow), 32'd0);

        // Glitchy RWDS and a stray fall with nothing pending
        tick(1'b1, rnd_dq(), 6'b101010, 1'b0);
        tick(1'b1, rnd_dq(), 6'b010101, 1'b0);
        tick(1'b1, rnd_dq(), 6'b110000, 1'b0);
        tick(1'b1, '0, 6'b000000, 1'b0);
        chk("t5_edge_err", 32'(edge_err), 32'd1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_if.o_valid) n++;
            tick(1'b1, '0, 6'b000000, 1'b1);
        end
        chk("t5_word_cnt", 32'(n), 32'd2);
        tick(1'b0, '0, 6'b000000, 1'b1);
        tick(1'b1, '0, 6'b000000, 1'b1);
        chk("t5_err_clear", 32'(edge_err), 32'd0);

        // Push counter
        do_reset();
        tick(1'b1, '0, 6'b000000, 1'b1);
        tick(1'b1, '0, 6'b000000, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, rnd_dq(), 6'b111000, 1'b1);
        tick(1'b1, '0, 6'b000000, 1'b1);
        tick(1'b1, '0, 6'b000000, 1'b1);
`ifdef HBMC_RX_WORD_COUNT_EN
        chk("t6_word_count", 32'(word_count), 32'd3);
`else
        chk("t6_word_count", 32'(word_count), 32'd0);
`endif

        // Randomized traffic, varying backpressure, one reset mid-stream
        lvl = '0;
        for (int blk = 0; blk < 16; blk++) begin
            int stall;
            stall = $urandom_range(0, 3);
            if (blk == 8) do_reset();
            for (int c = 0; c < 200; c++) begin
                logic [SW-1:0] rw;
                logic          en, rdy;
                en  = ($urandom_range(0, 15) != 0);
                rdy = ($urandom_range(0, 3) >= stall);
                case ($urandom_range(0, 3))
                    0:       rw = lvl;
                    1:       rw = SW'($urandom());
                    2:       rw = ~lvl;
                    default: rw = (SW'($urandom_range(0, 1)) << $urandom_range(0, SW - 1)) ^ lvl;
                endcase
                lvl = {SW{rw[0]}};
                tick(en, rnd_dq(), rw, rdy);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
